// File: rtl/scie_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : scie_cmd_queue
// Purpose  : Upstream command stage for the SCIE unpipelined datapath.
//            Buffers custom instructions (insn/rs1/rs2) in a DEPTH-entry
//            FIFO, presents the FIFO head to the combinational SCIE unit and
//            captures its result into a single response slot. The response
//            carries the destination register index taken from insn[11:7].
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clock          in   1       rising-edge clock
//   i_reset          in   1       asynchronous, active-high reset
//   i_req_valid      in   1       command offered
//   o_req_ready      out  1       queue can accept (low while full or in reset)
//   i_req_insn       in   32      instruction word
//   i_req_rs1        in   XLEN    source operand 1
//   i_req_rs2        in   XLEN    source operand 2
//   o_scie_insn      out  32      head instruction to SCIE unit (0 when empty)
//   o_scie_rs1       out  XLEN    head rs1 to SCIE unit (0 when empty)
//   o_scie_rs2       out  XLEN    head rs2 to SCIE unit (0 when empty)
//   i_scie_rd        in   XLEN    combinational result from SCIE unit
//   o_resp_valid     out  1       response held
//   i_resp_ready     in   1       core consumes response
//   o_resp_rd        out  XLEN    result value (0 for illegal commands)
//   o_resp_tag       out  5       insn[11:7] of the completed command
//   o_resp_illegal   out  1       head opcode differed from OPC
//   o_count          out  CW      current FIFO occupancy
// ============================================================================
module scie_cmd_queue #(
    parameter int         XLEN  = 32,
    parameter int         DEPTH = 4,
    parameter logic [6:0] OPC   = 7'h7B
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [31:0]              i_req_insn,
    input  logic [XLEN-1:0]          i_req_rs1,
    input  logic [XLEN-1:0]          i_req_rs2,
    output logic [31:0]              o_scie_insn,
    output logic [XLEN-1:0]          o_scie_rs1,
    output logic [XLEN-1:0]          o_scie_rs2,
    input  logic [XLEN-1:0]          i_scie_rd,
    output logic                     o_resp_valid,
    input  logic                     i_resp_ready,
    output logic [XLEN-1:0]          o_resp_rd,
    output logic [4:0]               o_resp_tag,
    output logic                     o_resp_illegal,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    // FIFO storage: no reset needed, validity is tracked by the pointers.
    logic [31:0]     r_mem_insn [DEPTH];
    logic [XLEN-1:0] r_mem_rs1  [DEPTH];
    logic [XLEN-1:0] r_mem_rs2  [DEPTH];

    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            r_resp_valid;
    logic [XLEN-1:0] r_resp_rd;
    logic [4:0]      r_resp_tag;
    logic            r_resp_illegal;

    logic            w_empty;
    logic            w_full;
    logic            w_enq;
    logic            w_load;
    logic            w_illegal;
    logic [31:0]     w_head_insn;
    logic [XLEN-1:0] w_head_rs1;
    logic [XLEN-1:0] w_head_rs2;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_FULL);

    // Readiness depends only on the registered occupancy, so a full queue
    // never accepts even when the head is dequeued in the same cycle.
    assign o_req_ready = !w_full && !i_reset;
    assign w_enq       = i_req_valid && o_req_ready;

    // Head is taken from registered storage only; gated to zero when empty.
    assign w_head_insn = w_empty ? '0 : r_mem_insn[r_rd_ptr];
    assign w_head_rs1  = w_empty ? '0 : r_mem_rs1[r_rd_ptr];
    assign w_head_rs2  = w_empty ? '0 : r_mem_rs2[r_rd_ptr];

    assign w_illegal = (w_head_insn[6:0] != OPC);

    // Move the head into the response slot whenever the slot is free or
    // is being consumed in this same cycle.
    assign w_load = !w_empty && (!r_resp_valid || i_resp_ready);

    always_ff @(posedge i_clock) begin
        if (w_enq) begin
            r_mem_insn[r_wr_ptr] <= i_req_insn;
            r_mem_rs1[r_wr_ptr]  <= i_req_rs1;
            r_mem_rs2[r_wr_ptr]  <= i_req_rs2;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_resp_valid   <= 1'b0;
            r_resp_rd      <= '0;
            r_resp_tag     <= '0;
            r_resp_illegal <= 1'b0;
        end else if (w_load) begin
            r_resp_valid   <= 1'b1;
            r_resp_rd      <= w_illegal ? '0 : i_scie_rd;
            r_resp_tag     <= w_head_insn[11:7];
            r_resp_illegal <= w_illegal;
        end else if (r_resp_valid && i_resp_ready) begin
            // Drain with nothing queued: payload fields hold their value.
            r_resp_valid   <= 1'b0;
        end
    end

    assign o_scie_insn    = w_head_insn;
    assign o_scie_rs1     = w_head_rs1;
    assign o_scie_rs2     = w_head_rs2;
    assign o_resp_valid   = r_resp_valid;
    assign o_resp_rd      = r_resp_rd;
    assign o_resp_tag     = r_resp_tag;
    assign o_resp_illegal = r_resp_illegal;
    assign o_count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_scie_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_scie_cmd_queue
// Purpose  : Self-checking bench for scie_cmd_queue. A queue-based reference
//            model tracks pending commands and the response slot; the SCIE
//            unit is stood in for by a signed ReLU on rs1.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_scie_cmd_queue;

    localparam int         XLEN  = 32;
    localparam int         DEPTH = 4;
    localparam logic [6:0] OPC   = 7'h7B;
    localparam int         CW    = $clog2(DEPTH) + 1;

    logic            i_clock = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_req_valid = 1'b0;
    logic            o_req_ready;
    logic [31:0]     i_req_insn = '0;
    logic [XLEN-1:0] i_req_rs1 = '0;
    logic [XLEN-1:0] i_req_rs2 = '0;
    logic [31:0]     o_scie_insn;
    logic [XLEN-1:0] o_scie_rs1;
    logic [XLEN-1:0] o_scie_rs2;
    logic [XLEN-1:0] w_scie_rd;
    logic            o_resp_valid;
    logic            i_resp_ready = 1'b0;
    logic [XLEN-1:0] o_resp_rd;
    logic [4:0]      o_resp_tag;
    logic            o_resp_illegal;
    logic [CW-1:0]   o_count;

    always #5 i_clock = ~i_clock;

    function automatic logic [XLEN-1:0] relu(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? '0 : x;
    endfunction

    assign w_scie_rd = relu(o_scie_rs1);

    scie_cmd_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .OPC(OPC)) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_insn     (i_req_insn),
        .i_req_rs1      (i_req_rs1),
        .i_req_rs2      (i_req_rs2),
        .o_scie_insn    (o_scie_insn),
        .o_scie_rs1     (o_scie_rs1),
        .o_scie_rs2     (o_scie_rs2),
        .i_scie_rd      (w_scie_rd),
        .o_resp_valid   (o_resp_valid),
        .i_resp_ready   (i_resp_ready),
        .o_resp_rd      (o_resp_rd),
        .o_resp_tag     (o_resp_tag),
        .o_resp_illegal (o_resp_illegal),
        .o_count        (o_count)
    );

    typedef struct {
        logic [31:0]     insn;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } cmd_t;

    cmd_t            mq[$];
    logic            m_rv  = 1'b0;
    logic [XLEN-1:0] m_rd  = '0;
    logic [4:0]      m_tag = '0;
    logic            m_ill = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; entered just after a rising edge.
    task automatic step(input logic v, input logic [31:0] insn,
                        input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                        input logic rr);
        logic acc, ld;
        cmd_t c, h;
        i_req_valid  = v;
        i_req_insn   = insn;
        i_req_rs1    = rs1;
        i_req_rs2    = rs2;
        i_resp_ready = rr;
        #1;
        chk("req_ready", 64'(o_req_ready), 64'(mq.size() < DEPTH));
        chk("count_pre", 64'(o_count), 64'(mq.size()));
        chk("scie_insn", 64'(o_scie_insn), (mq.size() != 0) ? 64'(mq[0].insn) : 64'd0);
        chk("scie_rs1",  64'(o_scie_rs1),  (mq.size() != 0) ? 64'(mq[0].rs1)  : 64'd0);
        chk("scie_rs2",  64'(o_scie_rs2),  (mq.size() != 0) ? 64'(mq[0].rs2)  : 64'd0);
        acc = v && (mq.size() < DEPTH);
        ld  = (mq.size() != 0) && (!m_rv || rr);
        @(posedge i_clock);
        #1;
        if (ld) begin
            h     = mq.pop_front();
            m_rv  = 1'b1;
            m_ill = (h.insn[6:0] != OPC);
            m_rd  = m_ill ? '0 : relu(h.rs1);
            m_tag = h.insn[11:7];
        end else if (m_rv && rr) begin
            m_rv = 1'b0;
        end
        if (acc) begin
            c.insn = insn; c.rs1 = rs1; c.rs2 = rs2;
            mq.push_back(c);
        end
        chk("resp_valid",   64'(o_resp_valid),   64'(m_rv));
        chk("resp_rd",      64'(o_resp_rd),      64'(m_rd));
        chk("resp_tag",     64'(o_resp_tag),     64'(m_tag));
        chk("resp_illegal", 64'(o_resp_illegal), 64'(m_ill));
        chk("count_post",   64'(o_count),        64'(mq.size()));
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 32'h0, '0, '0, rr);
    endtask

    task automatic model_reset();
        mq.delete();
        m_rv = 1'b0; m_rd = '0; m_tag = '0; m_ill = 1'b0;
    endtask

    // Drain everything with ready high; bounded.
    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while ((mq.size() != 0 || m_rv) && guard < 20) begin
            idle(1'b1);
            guard++;
        end
        chk(tag, 64'(mq.size() != 0 || m_rv), 64'd0);
    endtask

    logic [XLEN-1:0] t3_rs1 [8];
    logic [XLEN-1:0] t3_exp [8];

    initial begin
        // Reset state (asynchronous: visible before any edge).
        #1;
        chk("rst_count",   64'(o_count),        64'd0);
        chk("rst_ready",   64'(o_req_ready),    64'd0);
        chk("rst_rvalid",  64'(o_resp_valid),   64'd0);
        chk("rst_rd",      64'(o_resp_rd),      64'd0);
        chk("rst_tag",     64'(o_resp_tag),     64'd0);
        chk("rst_illegal", 64'(o_resp_illegal), 64'd0);
        chk("rst_scie",    64'(o_scie_insn),    64'd0);
        repeat (2) @(posedge i_clock);
        #1 i_reset = 1'b0;

        // 1. Single command, two-edge latency.
        step(1'b1, 32'h0000_007B, 32'd3328, 32'd0, 1'b1);
        chk("t1_not_yet", 64'(o_resp_valid), 64'd0);
        idle(1'b1);
        chk("t1_valid", 64'(o_resp_valid), 64'd1);
        chk("t1_rd",    64'(o_resp_rd),    64'd3328);
        chk("t1_tag",   64'(o_resp_tag),   64'd0);
        idle(1'b1);

        // 2. Negative operand clamps to zero through the SCIE stand-in.
        step(1'b1, 32'h7B | (32'd5 << 7), -32'sd5120, 32'd9, 1'b1);
        idle(1'b1);
        chk("t2_rd",      64'(o_resp_rd),      64'd0);
        chk("t2_tag",     64'(o_resp_tag),     64'd5);
        chk("t2_illegal", 64'(o_resp_illegal), 64'd0);
        idle(1'b1);

        // 3. Back-to-back at one command per cycle.
        t3_rs1 = '{32'd8192, -32'sd1, 32'd4352, 32'd2304, -32'sd77, 32'd11008, -32'sd3, 32'd9472};
        t3_exp = '{32'd8192, 32'd0, 32'd4352, 32'd2304, 32'd0, 32'd11008, 32'd0, 32'd9472};
        for (int i = 0; i < 9; i++) begin
            if (i < 8) step(1'b1, 32'h7B | (32'(i + 1) << 7), t3_rs1[i], 32'(i), 1'b1);
            else       idle(1'b1);
            if (i >= 1) begin
                chk("t3_valid", 64'(o_resp_valid), 64'd1);
                chk("t3_rd",    64'(o_resp_rd),    64'(t3_exp[i-1]));
                chk("t3_tag",   64'(o_resp_tag),   64'(i));
            end
        end
        idle(1'b1);

        // 4. Backpressure: slot holds first response, FIFO fills to DEPTH.
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h7B | (32'(10 + i) << 7), 32'(100 * (i + 1)), 32'd0, 1'b0);
        chk("t4_count", 64'(o_count),      64'd4);
        chk("t4_tag",   64'(o_resp_tag),   64'd10);
        chk("t4_rd",    64'(o_resp_rd),    64'd100);
        step(1'b1, 32'h7B | (32'd31 << 7), 32'd1, 32'd0, 1'b0); // refused: full
        chk("t4_full_hold", 64'(o_count), 64'd4);
        for (int j = 0; j < 4; j++) begin
            idle(1'b1);
            chk("t4_order", 64'(o_resp_tag), 64'(11 + j));
        end
        drain("t4_drain");

        // 5. Illegal opcode forces rd to zero.
        step(1'b1, 32'h0000_0033 | (32'd7 << 7), 32'd768, 32'd0, 1'b1);
        idle(1'b1);
        chk("t5_illegal", 64'(o_resp_illegal), 64'd1);
        chk("t5_rd",      64'(o_resp_rd),      64'd0);
        idle(1'b1);

        // 6. Reset with commands queued and a response pending.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h7B | (32'(20 + i) << 7), 32'd55, 32'd0, 1'b0);
        chk("t6_pre_count", 64'(o_count), 64'd3);
        i_reset = 1'b1;
        #1;
        chk("t6_count",  64'(o_count),      64'd0);
        chk("t6_rvalid", 64'(o_resp_valid), 64'd0);
        chk("t6_ready",  64'(o_req_ready),  64'd0);
        model_reset();
        @(posedge i_clock);
        #1 i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            chk("t6_no_stale", 64'(o_resp_valid), 64'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] insn;
            insn = $urandom;
            if ($urandom_range(3) != 0) insn[6:0] = OPC;
            step(1'($urandom_range(1)), insn, $urandom, $urandom, ($urandom_range(3) != 0));
        end
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
